// File: rtl/i2s_rx_fifo.sv
// I2S / left-justified stereo ADC receiver feeding a show-ahead FIFO of {left,right} pairs.
// LRCK pin edge to out_valid in 4-5 clk; full FIFO drops the incoming pair and sets sticky overflow unless a pop coincides.
module i2s_rx_fifo #(
  parameter int SAMPLE_W   = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int MODE       = 0
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic                          audio_BCLK,
  input  logic                          audio_ADCLRCK,
  input  logic                          audio_ADCDAT,
  input  logic                          enable,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SAMPLE_W-1:0]           out_left,
  output logic [SAMPLE_W-1:0]           out_right,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_overflow
);

  localparam int   AW       = $clog2(FIFO_DEPTH);
  localparam int   CW       = $clog2(SAMPLE_W + 1);
  localparam logic LEFT_LVL = (MODE != 0);

  typedef enum logic [1:0] {S_IDLE, S_SKIP, S_SHIFT, S_WAIT} state_t;
  localparam state_t START_ST = (MODE != 0) ? S_SHIFT : S_SKIP;

  logic [2:0] bclk_sync;
  logic [2:0] lrck_sync;
  logic [1:0] dat_sync;
  logic       bclk_rise;
  logic       lrck_edge;
  logic       enter_left;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
    end else begin
      bclk_sync <= {bclk_sync[1:0], audio_BCLK};
      lrck_sync <= {lrck_sync[1:0], audio_ADCLRCK};
      dat_sync  <= {dat_sync[0], audio_ADCDAT};
    end
  end

  assign bclk_rise  = bclk_sync[1] & ~bclk_sync[2];
  assign lrck_edge  = lrck_sync[1] ^ lrck_sync[2];
  assign enter_left = lrck_edge && (lrck_sync[1] == LEFT_LVL);

  state_t              state;
  logic                chan;
  logic [CW-1:0]       bit_cnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] aligned;
  logic [SAMPLE_W-1:0] left_hold;
  logic [SAMPLE_W-1:0] right_hold;
  logic                push_req;

  // Short half-frames come out MSB-aligned with zero LSBs.
  assign aligned = shreg << (CW'(SAMPLE_W) - bit_cnt);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      chan       <= 1'b0;
      bit_cnt    <= '0;
      shreg      <= '0;
      left_hold  <= '0;
      right_hold <= '0;
      push_req   <= 1'b0;
    end else begin
      push_req <= 1'b0;
      if (!enable) begin
        state   <= S_IDLE;
        chan    <= 1'b0;
        bit_cnt <= '0;
        shreg   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (enter_left) begin
              state   <= START_ST;
              chan    <= 1'b0;
              bit_cnt <= '0;
              shreg   <= '0;
            end
          end
          default: begin
            if (lrck_edge) begin
              if (!chan) begin
                left_hold <= aligned;
              end else begin
                right_hold <= aligned;
                push_req   <= 1'b1;
              end
              chan    <= ~chan;
              bit_cnt <= '0;
              shreg   <= '0;
              state   <= START_ST;
            end else if (bclk_rise) begin
              case (state)
                S_SKIP: state <= S_SHIFT;
                S_SHIFT: begin
                  shreg   <= {shreg[SAMPLE_W-2:0], dat_sync[1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == CW'(SAMPLE_W - 1)) state <= S_WAIT;
                end
                default: ;
              endcase
            end
          end
        endcase
      end
    end
  end

  logic [SAMPLE_W-1:0] mem_l [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_r [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic                full;
  logic                pop;
  logic                do_push;
  logic                drop;

  assign out_valid = (fifo_level != '0);
  assign out_left  = mem_l[rd_ptr];
  assign out_right = mem_r[rd_ptr];
  assign full      = (fifo_level == (AW + 1)'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign do_push   = push_req & (~full | pop);
  assign drop      = push_req & full & ~pop;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_l[i] <= '0;
        mem_r[i] <= '0;
      end
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) begin
        mem_l[wr_ptr] <= left_hold;
        mem_r[wr_ptr] <= right_hold;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: ;
      endcase
      // A drop in the same cycle as a clear must stay visible.
      if (drop)                overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_rx_fifo.sv
// Scoreboarded bench: dut0 is I2S (MODE 0), dut1 is left-justified (MODE 1), both 24-bit, depth 4, sharing the codec pins.
module tb_i2s_rx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        bclk, lrck, dat;
  logic        en0, en1, rdy0, rdy1, clr0, clr1;
  logic        v0, v1, ov0, ov1;
  logic [23:0] l0, r0, l1, r1;
  logic [2:0]  lvl0, lvl1;

  int passes = 0;
  int checks = 0;

  logic [47:0] q0[$];
  logic [47:0] q1[$];
  logic [47:0] e0, e1;

  logic [23:0] lt [6] = '{24'h100001, 24'h200002, 24'h300003, 24'h400004, 24'h500005, 24'h600006};
  logic [23:0] rt [6] = '{24'hF0000F, 24'hE0000E, 24'hD0000D, 24'hC0000C, 24'hB0000B, 24'hA0000A};

  always #5 clk = ~clk;

  i2s_rx_fifo #(.SAMPLE_W(24), .FIFO_DEPTH(4), .MODE(0)) dut0 (
    .clk_clk(clk), .reset_reset_n(rst_n), .audio_BCLK(bclk), .audio_ADCLRCK(lrck),
    .audio_ADCDAT(dat), .enable(en0), .out_valid(v0), .out_ready(rdy0), .out_left(l0),
    .out_right(r0), .fifo_level(lvl0), .overflow(ov0), .clear_overflow(clr0));

  i2s_rx_fifo #(.SAMPLE_W(24), .FIFO_DEPTH(4), .MODE(1)) dut1 (
    .clk_clk(clk), .reset_reset_n(rst_n), .audio_BCLK(bclk), .audio_ADCLRCK(lrck),
    .audio_ADCDAT(dat), .enable(en1), .out_valid(v1), .out_ready(rdy1), .out_left(l1),
    .out_right(r1), .fifo_level(lvl1), .overflow(ov1), .clear_overflow(clr1));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  // Monitor: compare every accepted head against the scoreboard.
  always @(negedge clk) begin
    #1;
    if (rst_n === 1'b1) begin
      if (v0 && rdy0) begin
        if (q0.size() == 0) begin
          checks++;
          $display("FAIL dut0_extra: got %h, expected no output", {l0, r0});
        end else begin
          e0 = q0.pop_front();
          chk("dut0_pair", 64'({l0, r0}), 64'(e0));
        end
      end
      if (v1 && rdy1) begin
        if (q1.size() == 0) begin
          checks++;
          $display("FAIL dut1_extra: got %h, expected no output", {l1, r1});
        end else begin
          e1 = q1.pop_front();
          chk("dut1_pair", 64'({l1, r1}), 64'(e1));
        end
      end
    end
  end

  // One half-frame of nb BCLK slots; LRCK and DAT change with the BCLK falling edge.
  task automatic half(input logic lvl, input logic [31:0] d, input int w, input int nb, input bit lj);
    int bp;
    for (int i = 0; i < nb; i++) begin
      bp = lj ? i : i - 1;
      @(negedge clk);
      bclk = 1'b0;
      if (i == 0) lrck = lvl;
      dat = (bp >= 0 && bp < w) ? d[w-1-bp] : 1'b0;
      repeat (3) @(negedge clk);
      @(negedge clk);
      bclk = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic frame(input bit lj, input int nb, input logic [31:0] l, input logic [31:0] r, input int w);
    half(lj, l, w, nb, lj);
    half(~lj, r, w, nb, lj);
  endtask

  // LRCK edge that closes the current half, optionally with a one-cycle out_ready pulse
  // landing exactly on the resulting FIFO push.
  task automatic tail(input logic lvl, input bit pulse);
    @(negedge clk);
    bclk = 1'b0;
    lrck = lvl;
    dat  = 1'b0;
    repeat (3) @(negedge clk);
    if (pulse) rdy0 = 1'b1;
    @(negedge clk);
    if (pulse) rdy0 = 1'b0;
    bclk = 1'b1;
    repeat (3) @(negedge clk);
    half(lvl, 32'h0, 0, 3, 1'b1);
  endtask

  task automatic park(input logic lvl);
    @(negedge clk);
    lrck = lvl;
    repeat (16) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(q0.size() + q1.size()), 64'd0);
  endtask

  initial begin
    rst_n = 1'b0; bclk = 1'b0; lrck = 1'b1; dat = 1'b0;
    en0 = 1'b0; en1 = 1'b0; rdy0 = 1'b1; rdy1 = 1'b1; clr0 = 1'b0; clr1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_valid0", 64'(v0), 64'd0);
    chk("rst_level0", 64'(lvl0), 64'd0);
    chk("rst_ovf0", 64'(ov0), 64'd0);
    chk("rst_data0", 64'({l0, r0}), 64'd0);
    chk("rst_valid1", 64'(v1), 64'd0);
    chk("rst_level_ovf1", 64'({lvl1, ov1}), 64'd0);
    rst_n = 1'b1;
    park(1'b1);

    // I2S basic pair
    en0 = 1'b1;
    q0.push_back({24'h123456, 24'hABCDEF});
    frame(1'b0, 32, 32'h123456, 32'hABCDEF, 24);
    tail(1'b0, 1'b0);
    en0 = 1'b0;
    drain();
    chk("a_level0", 64'(lvl0), 64'd0);

    // Left-justified stream into the I2S receiver: locks onto the right half, one bit early
    en0 = 1'b1;
    q0.push_back({24'h579BDE, 24'h000000});
    frame(1'b1, 32, 32'h123456, 32'hABCDEF, 24);
    tail(1'b1, 1'b0);
    tail(1'b0, 1'b0);
    en0 = 1'b0;
    drain();

    // Left-justified receiver, same data
    en1 = 1'b1;
    q1.push_back({24'h123456, 24'hABCDEF});
    frame(1'b1, 32, 32'h123456, 32'hABCDEF, 24);
    tail(1'b1, 1'b0);
    en1 = 1'b0;
    drain();

    // 16-bit words in 16-slot halves left-align with zero LSBs
    park(1'b0);
    en1 = 1'b1;
    q1.push_back({24'hBEEF00, 24'h123400});
    frame(1'b1, 16, 32'hBEEF, 32'h1234, 16);
    tail(1'b1, 1'b0);
    en1 = 1'b0;
    drain();

    // Overflow: six frames into a depth-4 FIFO with no consumer
    park(1'b1);
    rdy0 = 1'b0;
    en0  = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) q0.push_back({lt[k], rt[k]});
      frame(1'b0, 32, 32'(lt[k]), 32'(rt[k]), 24);
    end
    tail(1'b0, 1'b0);
    chk("d_level_full", 64'(lvl0), 64'd4);
    chk("d_overflow", 64'(ov0), 64'd1);
    chk("d_head_left", 64'(l0), 64'(lt[0]));
    chk("d_head_right", 64'(r0), 64'(rt[0]));
    clr0 = 1'b1;
    @(negedge clk);
    clr0 = 1'b0;
    @(negedge clk);
    chk("d_ovf_cleared", 64'(ov0), 64'd0);
    chk("d_level_kept", 64'(lvl0), 64'd4);
    rdy0 = 1'b1;
    drain();
    chk("d_level_empty", 64'(lvl0), 64'd0);
    en0 = 1'b0;

    // Enable raised mid-way through a left half: that frame is discarded
    park(1'b1);
    q0.push_back({24'h5A5A5A, 24'hC3C3C3});
    fork
      frame(1'b0, 32, 32'h0F0F0F, 32'h707070, 24);
      begin
        repeat (130) @(negedge clk);
        en0 = 1'b1;
      end
    join
    frame(1'b0, 32, 32'h5A5A5A, 32'hC3C3C3, 24);
    tail(1'b0, 1'b0);
    en0 = 1'b0;
    drain();
    chk("e_level0", 64'(lvl0), 64'd0);

    // Full FIFO with a pop landing on the same cycle as the push
    park(1'b1);
    rdy0 = 1'b0;
    en0  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      q0.push_back({lt[k], rt[k]});
      frame(1'b0, 32, 32'(lt[k]), 32'(rt[k]), 24);
    end
    tail(1'b0, 1'b1);
    repeat (4) @(negedge clk);
    chk("f_level_full", 64'(lvl0), 64'd4);
    chk("f_no_overflow", 64'(ov0), 64'd0);
    rdy0 = 1'b1;
    drain();
    chk("f_level_empty", 64'(lvl0), 64'd0);
    chk("f_ovf_final", 64'(ov0), 64'd0);
    en0 = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx_fifo.md
Name: i2s_rx_fifo

Overview:
- Parametrised I2S/left-justified audio receiver: deserialises stereo ADC data from the codec serial bus into parallel left/right sample pairs.
- Buffers pairs in a show-ahead FIFO with a valid/ready output handshake.
- Sits between the codec pins (audio_BCLK/audio_ADCLRCK/audio_ADCDAT) and downstream processing (frequency separation, level metering).
- Supersedes the fixed 24-bit single-mode path with configurable width, depth, framing mode and overflow reporting.

Parameters:
- SAMPLE_W, 24, bits captured per channel (MSB-first), 8..32.
- FIFO_DEPTH, 8, stereo pairs buffered, power of 2, >=2.
- MODE, 0, framing: 0 = I2S (left while LRCK low, MSB one BCLK after LRCK edge); 1 = left-justified (left while LRCK high, MSB on first BCLK after edge).

Ports:
- clk_clk  in  1  system clock; must be >= 4x BCLK frequency.
- reset_reset_n  in  1  asynchronous active-low reset.
- audio_BCLK  in  1  codec bit clock, asynchronous.
- audio_ADCLRCK  in  1  codec ADC word clock, asynchronous.
- audio_ADCDAT  in  1  codec serial data, asynchronous.
- enable  in  1  receiver enable.
- out_valid  out  1  FIFO head holds a pair.
- out_ready  in  1  consumer accepts the head.
- out_left  out  SAMPLE_W  head left sample.
- out_right  out  SAMPLE_W  head right sample.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  pairs stored.
- overflow  out  1  sticky: a frame was dropped.
- clear_overflow  in  1  clears overflow.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; all synchronisers 0.

Synchronisation:
- BCLK, LRCK and DAT each pass through a 2-flop synchroniser, plus a third flop for edge detection.
- bclk_rise = sync2 & ~sync3. LRCK edge = sync2 != sync3.
- DAT is sampled from its sync2 stage in the cycle bclk_rise is seen.

Left/right phase:
- "Left phase" = LRCK low (MODE 0) or LRCK high (MODE 1).

State machine:
- IDLE: wait for the LRCK edge entering left phase, then go to SKIP (MODE 0) or SHIFT (MODE 1). This discards any partial frame after enable or reset.
- SKIP: the first bclk_rise is ignored, then go to SHIFT.
- SHIFT: each bclk_rise shifts DAT into the current channel register MSB-first and increments bit_cnt. When bit_cnt reaches SAMPLE_W, go to WAIT.
- WAIT: ignore further bits until the next LRCK edge.
- Any LRCK edge in SKIP/SHIFT/WAIT ends the half-frame:
  - If fewer than SAMPLE_W bits were received, the sample is left-aligned with zero LSBs.
  - bit_cnt clears; the channel toggles; go to SKIP/SHIFT per MODE.
- The edge ending the right half pushes {left,right} into the FIFO; push is asserted in the cycle after edge detection.
- enable low: state forced to IDLE, partial frame discarded, FIFO contents and overflow retained. Popping continues.

FIFO:
- Show-ahead. out_valid = (level != 0); out_left/out_right reflect the head combinationally from storage.
- Pop when out_valid & out_ready.
- Push when not full → stored, and out_valid rises the next cycle if the FIFO was empty.
- Push when full without a same-cycle pop → pair dropped, overflow set.
- Push when full with a same-cycle pop → both occur, level unchanged, no overflow.
- Pop when empty: ignored.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_level updates the cycle after a push or pop.

Overflow:
- clear_overflow clears overflow.
- If a drop occurs in the same cycle as clear_overflow, set wins.

Reset mid-frame:
- Immediate clear of everything.
- The first pair is pushed only after a complete left and right half-frame.

Timing:
- End-to-end latency from the LRCK pin edge to out_valid is 4-5 clk.

Test Plan:
- MODE 0, SAMPLE_W 24, 32 BCLK per half, left 0x123456, right 0xABCDEF, out_ready=1 → one pair out_left=0x123456, out_right=0xABCDEF; out_valid high 1 cycle; fifo_level returns to 0.
- MODE 1, same stimulus, left during LRCK high → identical pair. Same stimulus with MODE 0 framing → mis-framed data (values shifted by one bit), checks mode selection.
- SAMPLE_W 24, 16 BCLK per half, left 0xBEEF, right 0x1234 → out_left=0xBEEF00, out_right=0x123400.
- FIFO_DEPTH 4, out_ready=0, send 6 frames → fifo_level=4, overflow=1, head = frame 1. Pulse clear_overflow → overflow=0. Raise out_ready → frames 1-4 in order.
- Enable (or release reset) midway through a left half → that frame is discarded; first output is the next complete frame.
- FIFO full, out_ready=1 with a push landing in the same cycle → level stays 4, overflow stays 0, order preserved.
